// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by both the receive and transmit paths:
// deframer state encoding, word-select polarity and the default channel width.
package i2s_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    // Word-select level for each channel slot (Philips I2S).
    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // Deframer states: hunting for a left-slot start, or inside a channel slot.
    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings the externally driven BCLK/WS/SD into the system clock domain
// through SYNC_STAGES flops each (SYNC_STAGES must be at least 2) and flags
// the system-clock cycle in which the synchronized BCLK goes 0 -> 1.
module i2s_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bclk,
    input  logic ws,
    input  logic sd,
    output logic bclk_rise,
    output logic ws_s,
    output logic sd_s
);

    logic [SYNC_STAGES-1:0] bclk_sr;
    logic [SYNC_STAGES-1:0] ws_sr;
    logic [SYNC_STAGES-1:0] sd_sr;
    logic                   bclk_d;

    // Synchronizer chains plus one extra BCLK flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sr <= '0;
            ws_sr   <= '0;
            sd_sr   <= '0;
            bclk_d  <= 1'b0;
        end else begin
            bclk_sr <= {bclk_sr[SYNC_STAGES-2:0], bclk};
            ws_sr   <= {ws_sr[SYNC_STAGES-2:0], ws};
            sd_sr   <= {sd_sr[SYNC_STAGES-2:0], sd};
            bclk_d  <= bclk_sr[SYNC_STAGES-1];
        end
    end

    // WS and SD travel through chains of equal depth, so they line up with the edge.
    assign bclk_rise = bclk_sr[SYNC_STAGES-1] & ~bclk_d;
    assign ws_s      = ws_sr[SYNC_STAGES-1];
    assign sd_s      = sd_sr[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_receiver.sv
// I2S slave receiver: deframes Philips I2S (one-bit WS delay, MSB first)
// sampled in the CLK domain and hands {left, right} words to the consumer.
// Optional build macro I2S_RX_PEAK_EN adds per-channel absolute peak meters
// (Peak_Left, Peak_Right, Peak_Clear).
//
// Output handshake: a word transfers on every CLK edge where Sample_Valid and
// Sample_Ready are both high. Sample_Valid, once raised, stays high and
// Sample_Data stays stable until that transfer; a frame completing while the
// previous word is still held (and not transferring this cycle) is dropped
// and Overrun is set.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int MAX_SLOT_BITS = 32,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic                    I2S_BCLK,
    input  logic                    I2S_WS,
    input  logic                    I2S_DATA,
    output logic [2*DATA_WIDTH-1:0] Sample_Data,
    output logic                    Sample_Valid,
    input  logic                    Sample_Ready,
    output logic                    Overrun,
    input  logic                    Overrun_Clear,
    output logic                    Sync_Lost,
`ifdef I2S_RX_PEAK_EN
    output logic [DATA_WIDTH-1:0]   Peak_Left,
    output logic [DATA_WIDTH-1:0]   Peak_Right,
    input  logic                    Peak_Clear,
`endif
    output i2s_state_e              dbg_state
);

    localparam int CNT_W = $clog2(MAX_SLOT_BITS + 1);
    localparam logic [DATA_WIDTH-1:0] MASK_MSB = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic                  bclk_rise;
    logic                  ws_s;
    logic                  sd_s;

    i2s_state_e            state_q;
    i2s_state_e            state_d;
    logic                  ws_prev_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] bit_mask_q;
    logic [DATA_WIDTH-1:0] left_q;
    logic [DATA_WIDTH-1:0] right_q;
    logic                  pub_pend_q;

    logic                  ws_change;
    logic                  slot_full;
    logic [DATA_WIDTH-1:0] slot_word;
    logic                  slot_start;
    logic                  shift_en;
    logic                  latch_left;
    logic                  latch_right;
    logic                  frame_err;
    logic                  publish;
    logic                  overrun_evt;

    i2s_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (CLK),
        .rst_n     (Reset),
        .bclk      (I2S_BCLK),
        .ws        (I2S_WS),
        .sd        (I2S_DATA),
        .bclk_rise (bclk_rise),
        .ws_s      (ws_s),
        .sd_s      (sd_s)
    );

    assign ws_change = bclk_rise && (ws_s != ws_prev_q);
    // A slot that has already taken MAX_SLOT_BITS-1 bits may not take another without a WS change.
    assign slot_full = (bit_cnt_q == CNT_W'(MAX_SLOT_BITS - 1));
    // The bit mask walks from MSB to zero, so bits past DATA_WIDTH fall away and short slots stay zero-padded.
    assign slot_word = shreg_q | (sd_s ? bit_mask_q : '0);

    // State register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= ALIGN;
        else        state_q <= state_d;
    end

    // Next state and per-bit datapath controls; every decision is taken on a bclk_rise.
    always_comb begin
        state_d     = state_q;
        slot_start  = 1'b0;
        shift_en    = 1'b0;
        latch_left  = 1'b0;
        latch_right = 1'b0;
        frame_err   = 1'b0;
        if (!Enable) begin
            state_d    = ALIGN;
            slot_start = 1'b1;
        end else if (bclk_rise) begin
            unique case (state_q)
                ALIGN: begin
                    // The bit carrying WS 1->0 ends an unknown right slot; the next bit is a left MSB.
                    if (ws_change && ws_s == WS_LEFT) begin
                        state_d    = LEFT;
                        slot_start = 1'b1;
                    end
                end
                LEFT: begin
                    if (ws_change && ws_s == WS_RIGHT) begin
                        latch_left = 1'b1;
                        state_d    = RIGHT;
                        slot_start = 1'b1;
                    end else if (slot_full) begin
                        frame_err  = 1'b1;
                        state_d    = ALIGN;
                        slot_start = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                    end
                end
                RIGHT: begin
                    if (ws_change && ws_s == WS_LEFT) begin
                        latch_right = 1'b1;
                        state_d     = LEFT;
                        slot_start  = 1'b1;
                    end else if (slot_full) begin
                        frame_err  = 1'b1;
                        state_d    = ALIGN;
                        slot_start = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                    end
                end
                default: begin
                    state_d    = ALIGN;
                    slot_start = 1'b1;
                end
            endcase
        end
    end

    // WS history is tracked even while disabled so re-enabling never sees a stale edge.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)         ws_prev_q <= 1'b0;
        else if (bclk_rise) ws_prev_q <= ws_s;
    end

    // Slot shift register, bit mask and slot bit counter.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            shreg_q    <= '0;
            bit_mask_q <= '0;
            bit_cnt_q  <= '0;
        end else if (slot_start) begin
            shreg_q    <= '0;
            bit_mask_q <= MASK_MSB;
            bit_cnt_q  <= '0;
        end else if (shift_en) begin
            shreg_q    <= slot_word;
            bit_mask_q <= bit_mask_q >> 1;
            bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
        end
    end

    // Completed channel words; a finished right slot arms the publish on the next cycle.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            left_q     <= '0;
            right_q    <= '0;
            pub_pend_q <= 1'b0;
        end else begin
            if (latch_left)  left_q  <= slot_word;
            if (latch_right) right_q <= slot_word;
            pub_pend_q <= latch_right;
        end
    end

    // Framing loss is reported as a single-cycle pulse.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) Sync_Lost <= 1'b0;
        else        Sync_Lost <= frame_err;
    end

    assign publish     = pub_pend_q & (~Sample_Valid | Sample_Ready);
    assign overrun_evt = pub_pend_q & Sample_Valid & ~Sample_Ready;

    // Output word register: a new frame takes the slot if it is empty or emptying this cycle.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            Sample_Data  <= '0;
            Sample_Valid <= 1'b0;
        end else if (publish) begin
            Sample_Data  <= {left_q, right_q};
            Sample_Valid <= 1'b1;
        end else if (Sample_Valid && Sample_Ready) begin
            Sample_Valid <= 1'b0;
        end
    end

    // Sticky overrun flag; a new overrun wins over a same-cycle clear.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)             Overrun <= 1'b0;
        else if (overrun_evt)   Overrun <= 1'b1;
        else if (Overrun_Clear) Overrun <= 1'b0;
    end

    assign dbg_state = state_q;

`ifdef I2S_RX_PEAK_EN
    localparam logic [DATA_WIDTH-1:0] MAX_POS = ~MASK_MSB;

    // Two's-complement magnitude; the most negative code saturates to the largest positive.
    function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] v);
        if (!v[DATA_WIDTH-1])  return v;
        else if (v == MASK_MSB) return MAX_POS;
        else                    return -v;
    endfunction

    logic [DATA_WIDTH-1:0] abs_left;
    logic [DATA_WIDTH-1:0] abs_right;

    assign abs_left  = abs_sat(left_q);
    assign abs_right = abs_sat(right_q);

    // Peak meters follow published frames only; a clear beats a same-cycle update.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            Peak_Left  <= '0;
            Peak_Right <= '0;
        end else if (Peak_Clear) begin
            Peak_Left  <= '0;
            Peak_Right <= '0;
        end else if (publish) begin
            if (abs_left > Peak_Left)   Peak_Left  <= abs_left;
            if (abs_right > Peak_Right) Peak_Right <= abs_right;
        end
    end
`endif

endmodule
